// File: rtl/alu_mdu_if.sv
// Bus bundle between the EX-stage controller and alu_mdu.
// The bundle carries the combinational ALU signals, the mult/div handshake and the Hi/Lo registers.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       ALUConf;
    logic             Sign;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             md_start;
    logic [1:0]       md_op;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output ALUConf, Sign, In1, In2, md_start, md_op,
        input  Result, Zero, md_busy, md_done, Hi, Lo
    );

    modport slave (
        input  ALUConf, Sign, In1, In2, md_start, md_op,
        output Result, Zero, md_busy, md_done, Hi, Lo
    );
endinterface

// File: rtl/alu_mdu.sv
// Combinational WIDTH-bit ALU plus an iterative multiply/divide unit with Hi/Lo registers.
// Define ALU_DIV_EN to build the restoring divider; without it DIV completes immediately and leaves Hi/Lo alone.
//
// state | meaning
// IDLE  | waiting for md_start
// RUN   | one multiply/divide bit per cycle, WIDTH cycles
// FIX   | sign correction, Hi/Lo written on exit
// DONE  | md_done pulse; a new start is accepted here too
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   p_hi, p_lo, opb;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               neg_q;
    logic               accept;
    logic               md_busy_c, md_done_c;

    logic [SHAMT_W-1:0] shamt;
    logic               lt;
    logic [WIDTH-1:0]   result_c;

    assign shamt = bus.In1[SHAMT_W-1:0];

    always_comb begin
        lt       = bus.Sign ? ($signed(bus.In1) < $signed(bus.In2)) : (bus.In1 < bus.In2);
        result_c = '0;
        case (bus.ALUConf)
            5'b00000: result_c = bus.In1 + bus.In2;
            5'b00001: result_c = bus.In1 | bus.In2;
            5'b00010: result_c = bus.In1 & bus.In2;
            5'b00110: result_c = bus.In1 - bus.In2;
            5'b01100: result_c = ~(bus.In1 | bus.In2);
            5'b01101: result_c = bus.In1 ^ bus.In2;
            5'b11010: result_c = bus.In1 & ~bus.In2;
            5'b00111: result_c = {{(WIDTH-1){1'b0}}, lt};
            5'b10000: result_c = bus.In2 >> shamt;
            5'b11000: result_c = $unsigned($signed(bus.In2) >>> shamt);
            5'b11001: result_c = bus.In2 << shamt;
            default:  result_c = '0;
        endcase
    end

    assign bus.Result = result_c;
    assign bus.Zero   = (result_c == '0);

    assign accept = bus.md_start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.md_start) begin
                    case (bus.md_op)
                        OP_MULT: state_nxt = RUN;
                        OP_DIV:
`ifdef ALU_DIV_EN
                            state_nxt = RUN;
`else
                            state_nxt = DONE;
`endif
                        default: state_nxt = DONE;
                    endcase
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        md_busy_c = (state == RUN) || (state == FIX);
        md_done_c = (state == DONE);
    end

    assign bus.md_busy = md_busy_c;
    assign bus.md_done = md_done_c;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;

    // Iterate on magnitudes; signs are folded back in FIX.
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    assign a_mag   = (bus.Sign && bus.In1[WIDTH-1]) ? -bus.In1 : bus.In1;
    assign b_mag   = (bus.Sign && bus.In2[WIDTH-1]) ? -bus.In2 : bus.In2;
    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
    assign prod    = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};

`ifdef ALU_DIV_EN
    logic             op_div, neg_r, dz;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH:0]   div_trial;

    assign div_trial = {p_hi, p_lo[WIDTH-1]} - {1'b0, opb};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            opb    <= '0;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef ALU_DIV_EN
            op_div <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            a_raw  <= '0;
`endif
        end else if (accept) begin
            cnt    <= SHAMT_W'(WIDTH - 1);
            p_hi   <= '0;
            p_lo   <= a_mag;
            opb    <= b_mag;
            neg_q  <= bus.Sign & (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
`ifdef ALU_DIV_EN
            op_div <= (bus.md_op == OP_DIV);
            neg_r  <= bus.Sign & bus.In1[WIDTH-1];
            dz     <= (bus.In2 == '0);
            a_raw  <= bus.In1;
`endif
            if (bus.md_op == OP_MTHI) hi_q <= bus.In1;
            if (bus.md_op == OP_MTLO) lo_q <= bus.In1;
        end else if (state == RUN) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
`ifdef ALU_DIV_EN
            if (op_div) begin
                if (!div_trial[WIDTH]) begin
                    p_hi <= div_trial[WIDTH-1:0];
                    p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                end else begin
                    p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
                    p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                p_hi <= mul_sum[WIDTH:1];
                p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end
        end else if (state == FIX) begin
`ifdef ALU_DIV_EN
            if (op_div) begin
                // Divide by zero reports all-ones quotient and the untouched dividend.
                if (dz) begin
                    lo_q <= '1;
                    hi_q <= a_raw;
                end else begin
                    lo_q <= neg_q ? -p_lo : p_lo;
                    hi_q <= neg_r ? -p_hi : p_hi;
                end
            end else
`endif
            begin
                hi_q <= prod[2*WIDTH-1:WIDTH];
                lo_q <= prod[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed ALU vectors plus a Hi/Lo scoreboard for mult/div/mthi/mtlo.
module tb_alu_mdu;
    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) bus ();
    alu_mdu_if #(.WIDTH(16)) bus16 ();

    alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
    alu_mdu #(.WIDTH(16), .SHAMT_W(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] sb_q[$];
    logic [31:0] hi_m, lo_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.md_done) begin
            if (sb_q.size() == 0) check("done_unexpected", {63'd0, bus.md_done}, 64'd0);
            else check("hilo", {bus.Hi, bus.Lo}, sb_q.pop_front());
        end
    end

    function automatic logic [63:0] md_model(input logic [1:0] op, input logic sg,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [63:0] cur);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        md_model = cur;
        case (op)
            OP_MULT: begin
                if (sg) begin
                    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                    md_model = sp;
                end else begin
                    md_model = {32'd0, a} * {32'd0, b};
                end
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
                if (b == 32'd0)                                        md_model = {a, 32'hFFFF_FFFF};
                else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) md_model = {32'd0, 32'h8000_0000};
                else if (sg)                                           md_model = {sa % sb, sa / sb};
                else                                                   md_model = {a % b, a / b};
`endif
            end
            OP_MTHI: md_model = {a, cur[31:0]};
            default: md_model = {cur[63:32], a};
        endcase
    endfunction

    task automatic alu_chk(input logic [4:0] conf, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        bus.ALUConf = conf;
        bus.Sign    = sg;
        bus.In1     = a;
        bus.In2     = b;
        #1;
        check($sformatf("alu_%b", conf), {32'd0, bus.Result}, {32'd0, exp});
        check($sformatf("zero_%b", conf), {63'd0, bus.Zero}, {63'd0, (exp == 32'd0)});
    endtask

    // Called at a negedge; the start is taken on the following posedge.
    task automatic run_md(input logic [1:0] op, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int ign_at, input int abort_at);
        int          n, busy_cnt, lat_exp;
        logic        iter;
        logic [63:0] held;
        logic [31:0] x, y, s;
`ifdef ALU_DIV_EN
        iter = (op == OP_MULT) || (op == OP_DIV);
`else
        iter = (op == OP_MULT);
`endif
        lat_exp  = iter ? W + 1 : 0;
        held     = {hi_m, lo_m};
        bus.ALUConf  = 5'b00000;
        bus.md_op    = op;
        bus.Sign     = sg;
        bus.In1      = a;
        bus.In2      = b;
        bus.md_start = 1'b1;
        sb_q.push_back(exp);
        n        = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            bus.md_start = 1'b0;
            bus.md_op    = 2'($urandom);
            bus.Sign     = 1'($urandom);
            bus.In1      = $urandom;
            bus.In2      = $urandom;
            if (n == ign_at) begin
                bus.md_start = 1'b1;
                bus.md_op    = OP_DIV;
            end
            if (bus.md_busy) busy_cnt++;
            if (!bus.md_done) check("hilo_hold", {bus.Hi, bus.Lo}, held);
            if (n == 3 && iter) begin
                x = $urandom;
                y = $urandom;
                s = x + y;
                bus.In1 = x;
                bus.In2 = y;
                #1;
                check("alu_while_busy", {32'd0, bus.Result}, {32'd0, s});
            end
            if (n == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("abort_busy", {63'd0, bus.md_busy}, 64'd0);
                check("abort_hilo", {bus.Hi, bus.Lo}, 64'd0);
                sb_q.delete();
                hi_m = '0;
                lo_m = '0;
                repeat (W + 4) begin
                    @(negedge clk);
                    check("abort_no_done", {63'd0, bus.md_done}, 64'd0);
                end
                return;
            end
        end while (!bus.md_done && n < 200);
        check("done_edge", 64'(n - 1), 64'(lat_exp));
        check("busy_cycles", 64'(busy_cnt), 64'(lat_exp));
        hi_m = exp[63:32];
        lo_m = exp[31:0];
    endtask

    initial begin
        int          n;
        logic [1:0]  op;
        logic        sg;
        logic [31:0] a, b;

        reset = 1'b1;
        bus.ALUConf = '0; bus.Sign = 1'b0; bus.In1 = '0; bus.In2 = '0;
        bus.md_start = 1'b0; bus.md_op = '0;
        bus16.ALUConf = '0; bus16.Sign = 1'b0; bus16.In1 = '0; bus16.In2 = '0;
        bus16.md_start = 1'b0; bus16.md_op = '0;
        hi_m = '0;
        lo_m = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
        check("rst_busy", {63'd0, bus.md_busy}, 64'd0);
        check("rst_done", {63'd0, bus.md_done}, 64'd0);

        alu_chk(5'b00000, 1'b0, 32'd5,          32'd7,          32'd12);
        alu_chk(5'b00001, 1'b0, 32'hF0,         32'h0F,         32'hFF);
        alu_chk(5'b00010, 1'b0, 32'hF0,         32'h3C,         32'h30);
        alu_chk(5'b00110, 1'b0, 32'd5,          32'd7,          32'hFFFF_FFFE);
        alu_chk(5'b00110, 1'b0, 32'd7,          32'd7,          32'd0);
        alu_chk(5'b01100, 1'b0, 32'hF0F0_F0F0,  32'h0F0F_0F00,  32'h0000_000F);
        alu_chk(5'b01101, 1'b0, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'hF0F0_F0F0);
        alu_chk(5'b11010, 1'b0, 32'hFF,         32'h0F,         32'hF0);
        alu_chk(5'b00111, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'd1);
        alu_chk(5'b00111, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0);
        alu_chk(5'b10000, 1'b0, 32'd4,          32'h8000_0000,  32'h0800_0000);
        alu_chk(5'b11000, 1'b0, 32'd5,          32'h8000_0000,  32'hFC00_0000);
        alu_chk(5'b11001, 1'b0, 32'h23,         32'd1,          32'd8);
        alu_chk(5'b00011, 1'b0, 32'd5,          32'd7,          32'd0);

        @(negedge clk);
        run_md(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
        run_md(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 0, 0);
`ifdef ALU_DIV_EN
        run_md(OP_DIV, 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 0);
        run_md(OP_DIV, 1'b0, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 0, 0);
        run_md(OP_DIV, 1'b1, 32'hFFFF_FFF7, 32'd0, 64'hFFFF_FFF7_FFFF_FFFF, 0, 0);
        run_md(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0);
        run_md(OP_DIV, 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 0);
`else
        run_md(OP_DIV, 1'b0, 32'd9, 32'd0, {hi_m, lo_m}, 0, 0);
`endif

        for (int i = 0; i < 8; i++) begin
`ifdef ALU_DIV_EN
            op = (i % 2 == 0) ? OP_MULT : OP_DIV;
`else
            op = OP_MULT;
`endif
            sg = 1'(i >> 1);
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom;
            run_md(op, sg, a, b, md_model(op, sg, a, b, {hi_m, lo_m}), 0, 0);
        end

        run_md(OP_MULT, 1'b1, 32'd100, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FD44, 10, 0);
        run_md(OP_MULT, 1'b0, 32'd1234, 32'd5678, 64'd7006652, 0, 20);

        @(negedge clk);
        run_md(OP_MTHI, 1'b0, 32'h1234, 32'd0, {32'h1234, lo_m}, 0, 0);
        run_md(OP_MULT, 1'b0, 32'd3, 32'd4, 64'd12, 0, 0);
        run_md(OP_MTLO, 1'b0, 32'hCAFE, 32'd0, {hi_m, 32'hCAFE}, 0, 0);

        bus16.md_op    = OP_MULT;
        bus16.Sign     = 1'b1;
        bus16.In1      = 16'h8000;
        bus16.In2      = 16'h8000;
        bus16.md_start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus16.md_start = 1'b0;
            bus16.In1      = 16'($urandom);
            bus16.In2      = 16'($urandom);
        end while (!bus16.md_done && n < 100);
        check("w16_done_edge", 64'(n - 1), 64'd17);
        check("w16_hilo", {32'd0, bus16.Hi, bus16.Lo}, 64'h4000_0000);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
